// File: rtl/lsr_serial_ctrl.sv
// Transmit sequencer: accepts parallel words over valid/ready and shifts them
// out MSB-first through an owned left-shift register, with hold, abort and idle gap.
module lsr_serial_ctrl #(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             hold,
    input  logic             abort,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [7:0]    GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]    bit_cnt, bit_cnt_n;
    logic [7:0]       gap_cnt, gap_cnt_n;
    logic             in_ready_n, out_valid_n, busy_n, done_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            bit_cnt   <= bit_cnt_n;
            gap_cnt   <= gap_cnt_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // The last shift leaves shreg all-zero, so out_bit is 0 in GAP and IDLE.
    assign out_bit = shreg[WIDTH-1];

    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        bit_cnt_n   = bit_cnt;
        gap_cnt_n   = gap_cnt;
        in_ready_n  = in_ready;
        out_valid_n = out_valid;
        busy_n      = busy;
        done_n      = 1'b0;

        case (state)
            IDLE: begin
                // abort is deliberately ignored here; a handshake still lands.
                if (in_ready && in_valid) begin
                    shreg_n     = in_data;
                    bit_cnt_n   = '0;
                    state_n     = SHIFT;
                    in_ready_n  = 1'b0;
                    out_valid_n = 1'b1;
                    busy_n      = 1'b1;
                end else begin
                    in_ready_n  = 1'b1;
                end
            end

            SHIFT: begin
                if (abort) begin
                    state_n     = IDLE;
                    shreg_n     = '0;
                    bit_cnt_n   = '0;
                    gap_cnt_n   = '0;
                    out_valid_n = 1'b0;
                    busy_n      = 1'b0;
                    in_ready_n  = 1'b1;
                end else if (!hold) begin
                    shreg_n   = {shreg[WIDTH-2:0], 1'b0};
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt_n   = '0;
                        out_valid_n = 1'b0;
                        done_n      = 1'b1;
                        if (GAP_CYCLES > 0) begin
                            state_n   = GAP;
                            gap_cnt_n = '0;
                        end else begin
                            state_n    = IDLE;
                            in_ready_n = 1'b1;
                            busy_n     = 1'b0;
                        end
                    end
                end
            end

            GAP: begin
                if (abort) begin
                    state_n     = IDLE;
                    shreg_n     = '0;
                    bit_cnt_n   = '0;
                    gap_cnt_n   = '0;
                    out_valid_n = 1'b0;
                    busy_n      = 1'b0;
                    in_ready_n  = 1'b1;
                end else if (gap_cnt == GAP_LAST) begin
                    state_n    = IDLE;
                    gap_cnt_n  = '0;
                    in_ready_n = 1'b1;
                    busy_n     = 1'b0;
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lsr_serial_ctrl.sv
// Directed bench for lsr_serial_ctrl: one instance with no gap, one with a 3-cycle gap.
// Checked vector order is {in_ready, out_valid, out_bit, busy, done}.
module tb_lsr_serial_ctrl;

    logic       clk = 1'b0;
    logic       rst, in_valid, hold, abort;
    logic [3:0] in_data;

    logic r0, v0, b0, y0, d0;
    logic r3, v3, b3, y3, d3;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lsr_serial_ctrl #(.WIDTH(4), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(r0), .hold(hold), .abort(abort),
        .out_bit(b0), .out_valid(v0), .busy(y0), .done(d0)
    );

    lsr_serial_ctrl #(.WIDTH(4), .GAP_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(r3), .hold(hold), .abort(abort),
        .out_bit(b3), .out_valid(v3), .busy(y3), .done(d3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk0(input string tag, input logic [4:0] exp);
        chk(tag, {r0, v0, b0, y0, d0}, exp);
    endtask

    task automatic chk3(input string tag, input logic [4:0] exp);
        chk(tag, {r3, v3, b3, y3, d3}, exp);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; hold = 1'b0; abort = 1'b0; in_data = 4'b0000;
        tick(); tick();
        chk0("reset_g0", 5'b00000);
        chk3("reset_g3", 5'b00000);

        // Reset then word 1011
        rst = 1'b0; in_data = 4'b1011; in_valid = 1'b1;
        tick(); chk0("rdy_after_rst", 5'b10000);
        tick(); chk0("w1011_b0", 5'b01110);
        in_valid = 1'b0; in_data = 4'b0000;
        tick(); chk0("w1011_b1", 5'b01010);
        tick(); chk0("w1011_b2", 5'b01110);
        tick(); chk0("w1011_b3", 5'b01110);
        tick(); chk0("w1011_done", 5'b10001);
        tick(); chk0("w1011_idle", 5'b10000);

        // Back-to-back 1010 then 0110 with in_valid held high
        in_data = 4'b1010; in_valid = 1'b1;
        tick(); chk0("b2b_a_b0", 5'b01110);
        in_data = 4'b0110;
        tick(); chk0("b2b_a_b1", 5'b01010);
        tick(); chk0("b2b_a_b2", 5'b01110);
        tick(); chk0("b2b_a_b3", 5'b01010);
        tick(); chk0("b2b_a_done", 5'b10001);
        tick(); chk0("b2b_b_b0", 5'b01010);
        tick(); chk0("b2b_b_b1", 5'b01110);
        tick(); chk0("b2b_b_b2", 5'b01110);
        tick(); chk0("b2b_b_b3", 5'b01010);
        tick(); chk0("b2b_b_done", 5'b10001);
        in_valid = 1'b0;
        tick(); chk0("b2b_idle", 5'b10000);

        // Hold for 2 cycles on bit 1 of 1001
        in_data = 4'b1001; in_valid = 1'b1;
        tick(); chk0("hold_b0", 5'b01110);
        in_valid = 1'b0;
        tick(); chk0("hold_b1", 5'b01010);
        hold = 1'b1;
        tick(); chk0("hold_frz1", 5'b01010);
        tick(); chk0("hold_frz2", 5'b01010);
        hold = 1'b0;
        tick(); chk0("hold_b2", 5'b01010);
        tick(); chk0("hold_b3", 5'b01110);
        tick(); chk0("hold_done", 5'b10001);
        tick(); chk0("hold_idle", 5'b10000);

        // Abort during bit 2 of 1100, then 0101 transmits cleanly
        in_data = 4'b1100; in_valid = 1'b1;
        tick(); chk0("abt_b0", 5'b01110);
        in_valid = 1'b0;
        tick(); chk0("abt_b1", 5'b01110);
        tick(); chk0("abt_b2", 5'b01010);
        abort = 1'b1;
        tick(); chk0("abt_cleared", 5'b10000);
        abort = 1'b0;
        tick(); chk0("abt_no_done", 5'b10000);
        in_data = 4'b0101; in_valid = 1'b1;
        tick(); chk0("post_abt_b0", 5'b01010);
        in_valid = 1'b0;
        tick(); chk0("post_abt_b1", 5'b01110);
        tick(); chk0("post_abt_b2", 5'b01010);
        tick(); chk0("post_abt_b3", 5'b01110);
        tick(); chk0("post_abt_done", 5'b10001);
        tick(); chk0("post_abt_idle", 5'b10000);

        // abort in IDLE is ignored and the handshake is accepted; then reset mid-word
        in_data = 4'b1000; in_valid = 1'b1; abort = 1'b1;
        tick(); chk0("idle_abort_acc", 5'b01110);
        in_valid = 1'b0; abort = 1'b0;
        tick(); chk0("rstmid_b1", 5'b01010);
        rst = 1'b1;
        tick(); chk0("rstmid_zero", 5'b00000);
        rst = 1'b0;
        tick(); chk0("rstmid_rdy", 5'b10000);

        // Gap insertion on the GAP_CYCLES=3 instance
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick(); chk3("gap_rdy", 5'b10000);
        in_data = 4'b1111; in_valid = 1'b1;
        tick(); chk3("gap_b0", 5'b01110);
        in_valid = 1'b0;
        tick(); chk3("gap_b1", 5'b01110);
        tick(); chk3("gap_b2", 5'b01110);
        tick(); chk3("gap_b3", 5'b01110);
        tick(); chk3("gap_done", 5'b00011);
        tick(); chk3("gap_c2", 5'b00010);
        tick(); chk3("gap_c3", 5'b00010);
        tick(); chk3("gap_rdy_again", 5'b10000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsr_serial_ctrl.md
Name: lsr_serial_ctrl

Overview:
- Transmit sequencer for the team's left-shift (MSB-first, serial-out) register datapath.
- Accepts parallel words over a valid/ready handshake and loads them into an internal WIDTH-bit left-shift register.
- Shifts each word out one bit per clock, supports stall (hold) and abort, and inserts a programmable idle gap between words.
- Sits between a parallel producer and any serial consumer. The shift register is owned by this block.

Parameters:
- WIDTH, 4, word length in bits; legal values 2..32.
- GAP_CYCLES, 0, idle cycles inserted after each word before in_ready reasserts; legal values 0..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- in_data  input  WIDTH  parallel word to transmit; bit WIDTH-1 is sent first.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block can accept a word.
- hold  input  1  stall request; freezes shifting while high.
- abort  input  1  discard the word in flight and return to IDLE.
- out_bit  output  1  serial data, equal to shreg[WIDTH-1].
- out_valid  output  1  out_bit carries a valid data bit this cycle.
- busy  output  1  high when state is not IDLE.
- done  output  1  one-cycle pulse when a word completes normally.

Behaviour:
- Reset, at a clk edge with rst=1:
  - state=IDLE, shreg=0, bit_cnt=0, gap_cnt=0.
  - in_ready=0, out_valid=0, busy=0, done=0, out_bit=0.
  - in_ready rises at the first edge with rst=0.
- rst overrides every other input, including mid-word.
- All outputs are registered. out_bit is taken directly from shreg.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready at an edge: shreg<=in_data, bit_cnt<=0, state<=SHIFT, in_ready<=0, out_valid<=1, busy<=1.
  - SHIFT: out_valid=1, out_bit = current bit.
    - At each edge with hold=0: shreg<={shreg[WIDTH-2:0],1'b0} and bit_cnt++.
    - At the edge where bit_cnt==WIDTH-1 and hold=0: out_valid<=0 and done<=1 for one cycle.
      - If GAP_CYCLES>0: state<=GAP, gap_cnt<=0.
      - If GAP_CYCLES=0: state<=IDLE, in_ready<=1, busy<=0.
    - hold=1: shreg and bit_cnt are frozen, out_bit is repeated, and out_valid stays 1. The consumer samples only when out_valid&~hold. A hold on the last bit delays done.
  - GAP: out_valid=0, out_bit=0, busy=1. gap_cnt increments each edge; hold is ignored. At the edge where gap_cnt==GAP_CYCLES-1: state<=IDLE, in_ready<=1, busy<=0.
- Latency and throughput:
  - Bit k of an accepted word is on out_bit during the (k+1)th cycle after the accept edge, counting hold-free cycles.
  - done is high in the cycle after the last bit. With GAP_CYCLES=0, in_ready is also high in that cycle, so a word accepted then starts on the next cycle.
  - Throughput is one word per WIDTH+1+GAP_CYCLES cycles.
- Abort, at an edge in SHIFT or GAP:
  - state<=IDLE, shreg<=0, bit_cnt<=0, gap_cnt<=0, out_valid<=0, busy<=0, in_ready<=1.
  - done is not asserted.
  - abort beats hold and beats normal completion on the same edge.
  - abort in IDLE is ignored; a handshake on that edge is accepted.
- in_data is sampled only at the accept edge. Changes to in_data during SHIFT have no effect.
- in_valid while in_ready=0 is not an error; the producer holds it until accepted.

Test Plan:
- Reset then word: release rst, in_data=4'b1011, in_valid=1 at the first in_ready edge → out_bit sequence 1,0,1,1 on the next 4 cycles with out_valid=1; done=1 on cycle 5; in_ready=1 on cycle 5.
- Back-to-back: GAP_CYCLES=0, words 4'b1010 then 4'b0110, in_valid held high → serial stream 1,0,1,0,(done),0,1,1,0,(done); in_ready low for exactly 4 cycles per word.
- Gap insertion: GAP_CYCLES=3, word 4'b1111 → after done, out_valid=0 and busy=1 for 3 cycles, then in_ready=1.
- Hold: word 4'b1001, hold=1 for 2 cycles while bit 1 is on out_bit → out_bit=0 for 3 cycles, the full sequence still completes as 1,0,0,1, and done is delayed by 2 cycles.
- Abort mid-word: word 4'b1100, abort=1 during the bit-2 cycle → next cycle out_valid=0, out_bit=0, busy=0, in_ready=1, done never pulses; a following word 4'b0101 transmits cleanly.
- Reset mid-word: rst=1 during bit 1 → next cycle all outputs 0 including in_ready; in_ready=1 one cycle after rst falls.
